// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared types and constants for the PLL lock sequencer
package pll_seq_pkg;

    typedef enum logic [2:0] {
        S_PLLRST   = 3'd0,
        S_WAITLOCK = 3'd1,
        S_STABLE   = 3'd2,
        S_RELEASE  = 3'd3,
        S_RUN      = 3'd4
    } seq_state_t;

    localparam int RELOCK_W = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// rtl/pll_lock_sequencer_if.sv - PLL control / domain reset bundle between sequencer and board
interface pll_lock_sequencer_if
    import pll_seq_pkg::*;
#(
    parameter int NUM_CLK = 3
);
    logic                pll_locked;
    logic                req_reset;
    logic                pll_rst;
    logic [NUM_CLK-1:0]  rst_out;
    logic                ready;
    logic [RELOCK_W-1:0] relock_cnt;
    logic [2:0]          state_o;

    // sequencer side
    modport master (
        input  pll_locked, req_reset,
        output pll_rst, rst_out, ready, relock_cnt, state_o
    );

    // PLL / host side
    modport slave (
        output pll_locked, req_reset,
        input  pll_rst, rst_out, ready, relock_cnt, state_o
    );
endinterface

// File: rtl/pll_lock_sequencer_sync2.sv
// rtl/pll_lock_sequencer_sync2.sv - two-flop synchronizer with async active-low clear
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_q;
    logic sync_q;

    // two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset pulse, lock debounce and staggered domain reset release
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_CLK      = 3,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 1000000,
    parameter int LOCK_STABLE  = 1024,
    parameter int STAGGER      = 8
) (
    input logic                   refclk,
    input logic                   rst_n,
    pll_lock_sequencer_if.master  bus
);
    localparam int CNT_MAX = max_int(max_int(RST_CYCLES, LOCK_TIMEOUT), max_int(LOCK_STABLE, STAGGER));
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int IDX_W   = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1;

    logic lk;

    seq_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                pll_rst_q, pll_rst_d;
    logic [NUM_CLK-1:0]  rst_out_q, rst_out_d;
    logic                ready_q, ready_d;
    logic [RELOCK_W-1:0] relock_q, relock_d;

    sync2 u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (bus.pll_locked),
        .q     (lk)
    );

    // next-state logic; req_reset overrides everything, including lock loss
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        pll_rst_d = pll_rst_q;
        rst_out_d = rst_out_q;
        ready_d   = ready_q;
        relock_d  = relock_q;
        if (bus.req_reset) begin
            state_d   = S_PLLRST;
            cnt_d     = '0;
            pll_rst_d = 1'b1;
            rst_out_d = '1;
            ready_d   = 1'b0;
        end else begin
            case (state_q)
                S_PLLRST: begin
                    if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                        state_d   = S_WAITLOCK;
                        cnt_d     = '0;
                        pll_rst_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_WAITLOCK: begin
                    if (lk) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        state_d   = S_PLLRST;
                        cnt_d     = '0;
                        pll_rst_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_STABLE: begin
                    if (!lk) begin
                        state_d = S_WAITLOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
                        state_d      = S_RELEASE;
                        cnt_d        = '0;
                        idx_d        = '0;
                        rst_out_d[0] = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_RELEASE, S_RUN: begin
                    if (!lk) begin
                        // lock lost: slam every domain back into reset at once
                        state_d   = S_WAITLOCK;
                        cnt_d     = '0;
                        rst_out_d = '1;
                        ready_d   = 1'b0;
                        if (relock_q != '1) begin
                            relock_d = relock_q + RELOCK_W'(1);
                        end
                    end else if (state_q == S_RELEASE) begin
                        if (idx_q == IDX_W'(NUM_CLK - 1)) begin
                            state_d = S_RUN;
                            ready_d = 1'b1;
                        end else if (cnt_q == CNT_W'(STAGGER - 1)) begin
                            cnt_d            = '0;
                            idx_d            = idx_q + IDX_W'(1);
                            rst_out_d[idx_d] = 1'b0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d   = S_PLLRST;
                    cnt_d     = '0;
                    pll_rst_d = 1'b1;
                    rst_out_d = '1;
                    ready_d   = 1'b0;
                end
            endcase
        end
    end

    // state, counters and registered outputs
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_PLLRST;
            cnt_q     <= '0;
            idx_q     <= '0;
            pll_rst_q <= 1'b1;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            relock_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pll_rst_q <= pll_rst_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            relock_q  <= relock_d;
        end
    end

    assign bus.pll_rst    = pll_rst_q;
    assign bus.rst_out    = rst_out_q;
    assign bus.ready      = ready_q;
    assign bus.relock_cnt = relock_q;
    assign bus.state_o    = state_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - scoreboard bench for pll_lock_sequencer
module tb_pll_lock_sequencer;

    logic refclk;
    logic rst_n;
    int   cyc;
    int   n_assert;
    int   n_fail;

    typedef struct {
        int         cyc;
        logic       pr;
        logic [2:0] ro;
        logic       rd;
        logic [7:0] rc;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         mon_e;
    logic [12:0] prev_v;
    logic [12:0] cur_v;
    logic [12:0] want_v;

    pll_lock_sequencer_if #(.NUM_CLK(3)) bus ();

    pll_lock_sequencer #(
        .NUM_CLK      (3),
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (50),
        .LOCK_STABLE  (10),
        .STAGGER      (3)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    always @(posedge refclk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic void exp_ev(input int c, input logic pr, input logic [2:0] ro,
                                   input logic rd, input int rc);
        ev_t e;
        e.cyc = c;
        e.pr  = pr;
        e.ro  = ro;
        e.rd  = rd;
        e.rc  = rc[7:0];
        exp_q.push_back(e);
    endfunction

    // lock first sampled at edge l: bit0 at l+12, then every 3 cycles, ready one after
    function automatic void exp_release(input int l, input int rc);
        exp_ev(l + 12, 1'b0, 3'b110, 1'b0, rc);
        exp_ev(l + 15, 1'b0, 3'b100, 1'b0, rc);
        exp_ev(l + 18, 1'b0, 3'b000, 1'b0, rc);
        exp_ev(l + 19, 1'b0, 3'b000, 1'b1, rc);
    endfunction

    // monitor: every output change is one popped expectation
    always @(negedge refclk) begin
        cur_v = {bus.pll_rst, bus.rst_out, bus.ready, bus.relock_cnt};
        if (!rst_n) begin
            prev_v = cur_v;
        end else if (cur_v !== prev_v) begin
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event cyc=%0d got=%h", cyc, cur_v);
            end else begin
                mon_e  = exp_q.pop_front();
                want_v = {mon_e.pr, mon_e.ro, mon_e.rd, mon_e.rc};
                if (mon_e.cyc != cyc || cur_v !== want_v) begin
                    n_fail++;
                    $display("FAIL output_event got cyc=%0d {pll_rst,rst_out,ready,relock}=%h, want cyc=%0d %h",
                             cyc, cur_v, mon_e.cyc, want_v);
                end
            end
            prev_v = cur_v;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pll_rst"}, 32'(bus.pll_rst), 32'd1);
        check({tag, "_rst_out"}, 32'(bus.rst_out), 32'd7);
        check({tag, "_ready"},   32'(bus.ready), 32'd0);
        check({tag, "_relock"},  32'(bus.relock_cnt), 32'd0);
        check({tag, "_state"},   32'(bus.state_o), 32'd0);
    endtask

    // park on the negedge just before edge n so inputs set now are sampled at edge n
    task automatic at_edge(input int n);
        if (cyc > n - 1) begin
            n_fail++;
            $display("FAIL schedule cyc=%0d target=%0d", cyc, n - 1);
        end
        while (cyc < n - 1) @(negedge refclk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        bus.pll_locked = 1'b0;
        bus.req_reset  = 1'b0;
        repeat (2) @(negedge refclk);
        check_reset("por");
        rst_n = 1'b1;

        // lock never rises: pll_rst re-pulses every 54 cycles
        exp_ev(4,   1'b0, 3'b111, 1'b0, 0);
        exp_ev(54,  1'b1, 3'b111, 1'b0, 0);
        exp_ev(58,  1'b0, 3'b111, 1'b0, 0);
        exp_ev(108, 1'b1, 3'b111, 1'b0, 0);
        exp_ev(112, 1'b0, 3'b111, 1'b0, 0);
        exp_ev(162, 1'b1, 3'b111, 1'b0, 0);
        exp_ev(166, 1'b0, 3'b111, 1'b0, 0);
        at_edge(31);
        check("nolock_state_waitlock", 32'(bus.state_o), 32'd1);

        // one-cycle glitch when the stable count is 7: full debounce restarts
        at_edge(180);
        bus.pll_locked = 1'b1;
        at_edge(188);
        bus.pll_locked = 1'b0;
        exp_release(189, 0);
        at_edge(189);
        bus.pll_locked = 1'b1;
        at_edge(196);
        check("glitch_state_stable", 32'(bus.state_o), 32'd2);
        at_edge(216);
        check("glitch_relock", 32'(bus.relock_cnt), 32'd0);
        check("glitch_state_run", 32'(bus.state_o), 32'd4);

        #2 rst_n = 1'b0;
        bus.pll_locked = 1'b0;
        repeat (2) @(negedge refclk);
        check_reset("rst2");
        rst_n = 1'b1;

        // power-up with lock at cycle 20
        exp_ev(4, 1'b0, 3'b111, 1'b0, 0);
        at_edge(20);
        bus.pll_locked = 1'b1;
        exp_release(20, 0);

        // lock loss in run, then relock without a pll_rst pulse
        at_edge(50);
        bus.pll_locked = 1'b0;
        exp_ev(52, 1'b0, 3'b111, 1'b0, 1);
        at_edge(60);
        bus.pll_locked = 1'b1;
        exp_release(60, 1);

        // req_reset coincident with lock loss
        at_edge(90);
        bus.pll_locked = 1'b0;
        at_edge(92);
        bus.req_reset = 1'b1;
        exp_ev(92, 1'b1, 3'b111, 1'b0, 1);
        exp_ev(96, 1'b0, 3'b111, 1'b0, 1);
        at_edge(93);
        bus.req_reset = 1'b0;
        at_edge(110);
        bus.pll_locked = 1'b1;
        exp_release(110, 1);

        // 300 more lock losses: relock_cnt saturates
        for (int i = 0; i < 300; i++) begin
            int b;
            int rc;
            b  = 150 + 25 * i;
            rc = (i + 2 > 255) ? 255 : i + 2;
            at_edge(b);
            bus.pll_locked = 1'b0;
            exp_ev(b + 2, 1'b0, 3'b111, 1'b0, rc);
            at_edge(b + 3);
            bus.pll_locked = 1'b1;
            exp_release(b + 3, rc);
        end
        at_edge(7650);
        check("sat_relock", 32'(bus.relock_cnt), 32'd255);

        // one more loss at saturation, then async reset in the middle of release
        bus.pll_locked = 1'b0;
        exp_ev(7652, 1'b0, 3'b111, 1'b0, 255);
        at_edge(7653);
        bus.pll_locked = 1'b1;
        exp_ev(7665, 1'b0, 3'b110, 1'b0, 255);
        at_edge(7667);
        check("release_state", 32'(bus.state_o), 32'd3);
        check("release_rst_out", 32'(bus.rst_out), 32'd6);
        #2 rst_n = 1'b0;
        #1 check_reset("async");
        repeat (2) @(negedge refclk);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
